// File: rtl/key_event_pkg.sv
// Shared constants, counter-width helper and per-channel state type for key_event_detect.
package key_event_pkg;

    localparam int unsigned DEF_N_KEYS       = 16;
    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_TICK_DIV     = 4;
    localparam int unsigned DEF_DB_TICKS     = 3;
    localparam int unsigned DEF_LONG_TICKS   = 8;
    localparam int unsigned DEF_REPEAT_TICKS = 2;

    // Per-channel counters are sized for tick counts up to 2**CNT_W.
    localparam int unsigned CNT_W = 16;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [CNT_W-1:0] db_cnt;
        logic [CNT_W-1:0] hold_cnt;
        logic [CNT_W-1:0] rpt_cnt;
        logic             long_flag;
    } chan_state_t;

endpackage

// File: rtl/key_event_channel.sv
// One key channel: tick-timed debounce, press/release pulses, long-press and auto-repeat.
module key_event_channel
    import key_event_pkg::*;
#(
    parameter int unsigned DB_TICKS     = DEF_DB_TICKS,
    parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_s,
    input  logic tick,
    input  logic repeat_en,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    chan_state_t r_st;
    logic        r_state;
    logic        r_press;
    logic        r_release;
    logic        r_long;
    logic        r_repeat;

    logic        w_flip;
    logic        w_fall;

    // A falling flip this edge suppresses any long/repeat pulse in the release cycle.
    assign w_flip = (key_s != r_state) && tick && (r_st.db_cnt == DB_LAST);
    assign w_fall = w_flip && r_state;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_st      <= '0;
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;

            if (key_s == r_state) begin
                r_st.db_cnt <= '0;
            end else if (tick) begin
                if (w_flip) begin
                    r_st.db_cnt <= '0;
                    r_state     <= key_s;
                    r_press     <= key_s;
                    r_release   <= ~key_s;
                end else begin
                    r_st.db_cnt <= r_st.db_cnt + CNT_ONE;
                end
            end

            // Hold timing runs only while the debounced level is high.
            if (!r_state) begin
                r_st.hold_cnt  <= '0;
                r_st.rpt_cnt   <= '0;
                r_st.long_flag <= 1'b0;
            end else if (!w_fall) begin
                if (!r_st.long_flag) begin
                    if (tick) begin
                        if (r_st.hold_cnt == LONG_LAST) begin
                            r_long         <= 1'b1;
                            r_st.long_flag <= 1'b1;
                            r_st.rpt_cnt   <= '0;
                        end else begin
                            r_st.hold_cnt <= r_st.hold_cnt + CNT_ONE;
                        end
                    end
                end else if (!repeat_en) begin
                    r_st.rpt_cnt <= '0;
                end else if (tick) begin
                    if (r_st.rpt_cnt == RPT_LAST) begin
                        r_repeat     <= 1'b1;
                        r_st.rpt_cnt <= '0;
                    end else begin
                        r_st.rpt_cnt <= r_st.rpt_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

    assign key_state   = r_state;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_long    = r_long;
    assign key_repeat  = r_repeat;

endmodule

// File: rtl/key_event_detect.sv
// Keypad event detector: synchronises N raw keys, shares a debounce tick prescaler,
// and runs one key_event_channel per key.
module key_event_detect
    import key_event_pkg::*;
#(
    parameter int unsigned N_KEYS       = DEF_N_KEYS,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned DB_TICKS     = DEF_DB_TICKS,
    parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
    parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_KEYS-1:0] key,
    input  logic              repeat_en,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int unsigned       TICK_W    = cnt_width(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    logic [N_KEYS-1:0] r_sync [SYNC_STAGES];
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [N_KEYS-1:0] w_key_s;

    assign w_tick  = (r_tick_cnt == TICK_LAST);
    assign w_key_s = r_sync[SYNC_STAGES-1];

    // Raw-key synchroniser chain and shared debounce tick prescaler.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync[0] <= key;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_ONE;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_event_channel #(
            .DB_TICKS     (DB_TICKS),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_ch (
            .clk         (clk),
            .rstn        (rstn),
            .key_s       (w_key_s[g]),
            .tick        (w_tick),
            .repeat_en   (repeat_en),
            .key_state   (key_state[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g]),
            .key_repeat  (key_repeat[g])
        );
    end

endmodule

// File: doc/key_event_detect.md
# key_event_detect

Parametrised successor to the matrix-keypad edge capture stage. Sits between the matrix scanner and the password-lock control logic. Takes N raw key levels and performs the following per key:
- synchronisation;
- debounce, timed by a shared tick prescaler;
- one-cycle press and release pulses;
- one long-press pulse;
- optional auto-repeat pulses.

## Interface
- N_KEYS, 16: number of independent key channels
- SYNC_STAGES, 2: synchroniser depth on raw keys (≥2)
- TICK_DIV, 4: clk cycles per debounce tick (≥1; 1 = tick every cycle)
- DB_TICKS, 3: consecutive ticks of disagreement before the debounced state flips (≥1)
- LONG_TICKS, 8: ticks held after press before the long pulse (≥1)
- REPEAT_TICKS, 2: ticks between repeat pulses after long (≥1)
- clk  in  1  system clock; one clock domain
- rstn  in  1  reset, synchronous and active-low
- key  in  N_KEYS  raw key levels, 1 = pressed, asynchronous
- repeat_en  in  1  enables auto-repeat pulses, synchronous to clk
- key_state  out  N_KEYS  debounced level
- key_press  out  N_KEYS  one-cycle pulse on debounced 0→1
- key_release  out  N_KEYS  one-cycle pulse on debounced 1→0
- key_long  out  N_KEYS  one-cycle pulse when held LONG_TICKS ticks
- key_repeat  out  N_KEYS  one-cycle pulse every REPEAT_TICKS ticks after long, while repeat_en=1

## Operation
- **Reset:** rstn=0 at a clk edge clears everything to 0: sync flops, prescaler, all per-key counters and flags, all outputs.
- **Synchroniser:** key passes through SYNC_STAGES flops; the last stage is key_s.
- **Prescaler:** tick_cnt counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle tick_cnt==TICK_DIV-1. The tick is shared by all channels.
- **Debounce, per key:**
  - key_s==key_state: db_cnt←0.
  - Else on tick: db_cnt←db_cnt+1.
  - When db_cnt==DB_TICKS-1 on tick: key_state←key_s and db_cnt←0.
  - Any single cycle of agreement restarts the count, so bounces shorter than the window are rejected.
- **Press/release:** registered together with the key_state update. key_press (key_release) is high exactly in the first cycle key_state reads 1 (0).
- **Hold, per key:**
  - While key_state=1, hold_cnt increments on tick.
  - On the tick where hold_cnt==LONG_TICKS-1: key_long pulses, long_flag←1, rpt_cnt←0, hold_cnt stops.
  - With long_flag=1 and repeat_en=1: rpt_cnt increments on tick. On the tick where rpt_cnt==REPEAT_TICKS-1: key_repeat pulses and rpt_cnt←0.
  - With repeat_en=0: rpt_cnt is held at 0 and no repeat pulses are produced.
  - key_state=0 clears hold_cnt, rpt_cnt and long_flag.
- **Long pulse:** fires at most once per press. A release always produces key_release, including after a long press.
- **Channel independence:** channels are fully independent. Any combination of outputs may pulse in the same cycle across keys.
- **Same-cycle events within a channel:** key_press and key_long are never coincident (LONG_TICKS≥1). key_release in a cycle suppresses long/repeat in that cycle.
- **Reset mid-press:** a key held through reset yields a fresh key_press after the debounce window. No release pulse is emitted for the pre-reset press.

## Timing
- **Press/release latency:** debounced state flips (and key_press/key_release pulse) (DB_TICKS-1)·TICK_DIV+1 to DB_TICKS·TICK_DIV cycles after key_s first differs, depending on prescaler phase.
- **Raw-input latency:** add SYNC_STAGES cycles from the raw key to key_s.
- **Long latency:** key_long occurs between (LONG_TICKS-1)·TICK_DIV+1 and LONG_TICKS·TICK_DIV cycles after key_press.
- **Repeat spacing:** repeat pulses are exactly REPEAT_TICKS·TICK_DIV cycles apart.
- **Pulse width:** all pulses are exactly 1 cycle wide. All outputs are registered; there are no combinational paths from input to output.

## Structure
- **Package key_event_pkg:**
  - counter-width helper (clog2-based);
  - default parameter constants;
  - the per-channel state typedef (db_cnt, hold_cnt, rpt_cnt, long_flag).
- **Top level:** holds the synchroniser and prescaler.
- **Sub-module key_event_channel:** debounce, pulse and hold logic for one key. Instantiated N_KEYS times in a generate loop.

## Test plan
All scenarios use default parameters.
- **Clean press:** key[3] rises and holds. key_press[3] pulses once 11–14 cycles after the raw edge and key_state[3]=1; no other key_press bit asserts.
- **Bounce rejection:** key[0] toggles every 5 cycles for 60 cycles, then holds 1.
  - No pulses during toggling.
  - Exactly one key_press[0] 11–14 cycles after the final edge.
- **Long and repeat:** key[5] held with repeat_en=1.
  - key_long[5] 29–32 cycles after key_press[5].
  - key_repeat[5] every 8 cycles thereafter.
  - On release: one key_release[5], no further long or repeat pulses.
- **Repeat disabled:** same hold with repeat_en=0. key_long[5] pulses once, key_repeat stays 0. Raising repeat_en mid-hold gives the first repeat 8 cycles later.
- **Simultaneous keys:** key[0] and key[15] rise in the same cycle. key_press[0] and key_press[15] pulse in the same cycle.
- **Reset mid-hold:** rstn=0 for 1 cycle during the hold.
  - All outputs read 0 the next cycle.
  - The key, still held, produces a new key_press 11–14 cycles after rstn returns to 1.
